// File: rtl/bcd_scan_display_pkg.sv
// Purpose: shared constants for the four-digit multiplexed seven-segment scanner.
// Latency: n/a (constants only).
// Backpressure: n/a.
// Segment patterns are active-low and ordered {g,f,e,d,c,b,a}, bit 0 = segment a.
package bcd_scan_display_pkg;

    localparam int DIGIT_COUNT = 4;

    localparam logic [6:0] SEG_0    = 7'b1000000;
    localparam logic [6:0] SEG_1    = 7'b1111001;
    localparam logic [6:0] SEG_2    = 7'b0100100;
    localparam logic [6:0] SEG_3    = 7'b0110000;
    localparam logic [6:0] SEG_4    = 7'b0011001;
    localparam logic [6:0] SEG_5    = 7'b0010010;
    localparam logic [6:0] SEG_6    = 7'b0000010;
    localparam logic [6:0] SEG_7    = 7'b1111000;
    localparam logic [6:0] SEG_8    = 7'b0000000;
    localparam logic [6:0] SEG_9    = 7'b0010000;
    localparam logic [6:0] SEG_DASH = 7'b0111111;
    localparam logic [6:0] SEG_OFF  = 7'b1111111;

endpackage

// File: rtl/bcd_scan_display_bcd_to_7seg.sv
// Purpose: BCD code to active-low seven-segment pattern; codes 10-15 show a dash.
// Latency: combinational.
// Backpressure: none.
// Ports: code (4-bit BCD digit in), pattern (7-bit {g,f,e,d,c,b,a}, active-low out).
module bcd_to_7seg
    import bcd_scan_display_pkg::*;
(
    input  logic [3:0] code,
    output logic [6:0] pattern
);

    always_comb begin
        pattern = SEG_DASH;
        case (code)
            4'd0:    pattern = SEG_0;
            4'd1:    pattern = SEG_1;
            4'd2:    pattern = SEG_2;
            4'd3:    pattern = SEG_3;
            4'd4:    pattern = SEG_4;
            4'd5:    pattern = SEG_5;
            4'd6:    pattern = SEG_6;
            4'd7:    pattern = SEG_7;
            4'd8:    pattern = SEG_8;
            4'd9:    pattern = SEG_9;
            default: pattern = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/bcd_scan_display.sv
// Purpose: time-multiplexed driver for a 4-digit common-anode seven-segment display.
// Latency: one cycle from scan state to the registered an/seg/dp outputs.
// Backpressure: none; enable low blanks the display and freezes the scan in place.
// Ports: clk, reset (async, active-high), enable, bcd_in[15:0] (digit 3 in [15:12]),
//        dp_in[3:0], blank_lz (leading-zero suppression), an[3:0], seg[6:0], dp
//        (all outputs active-low). REFRESH_DIV = cycles each digit stays lit (>= 2).
module bcd_scan_display
    import bcd_scan_display_pkg::*;
#(
    parameter int unsigned REFRESH_DIV = 50000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic [15:0] bcd_in,
    input  logic [3:0]  dp_in,
    input  logic        blank_lz,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp
);

    localparam int PW = $clog2(REFRESH_DIV);
    localparam logic [PW-1:0] PRE_LAST = PW'(REFRESH_DIV - 1);

    logic [PW-1:0]            prescaler;
    logic [1:0]               index;
    logic [4*DIGIT_COUNT-1:0] shadow_bcd;
    logic [DIGIT_COUNT-1:0]   shadow_dp;
    logic                     shadow_blz;

    logic                     load;
    logic                     tick;
    logic [4*DIGIT_COUNT-1:0] eff_bcd;
    logic [DIGIT_COUNT-1:0]   eff_dp;
    logic                     eff_blz;
    logic [3:0]               code;
    logic [6:0]               pattern;
    logic                     blank_digit;
    logic                     z3, z2, z1;

    // A frame is latched at the start of digit 0. The decode path uses the
    // value being captured on that same cycle, so digit 0 of a new frame is
    // drawn from the same snapshot as digits 1-3.
    assign load    = enable && (index == 2'd0) && (prescaler == '0);
    assign tick    = enable && (prescaler == PRE_LAST);
    assign eff_bcd = load ? bcd_in   : shadow_bcd;
    assign eff_dp  = load ? dp_in    : shadow_dp;
    assign eff_blz = load ? blank_lz : shadow_blz;

    assign code = eff_bcd[{index, 2'b00} +: 4];

    bcd_to_7seg u_dec (
        .code    (code),
        .pattern (pattern)
    );

    assign z3 = (eff_bcd[15:12] == 4'd0);
    assign z2 = (eff_bcd[11:8]  == 4'd0);
    assign z1 = (eff_bcd[7:4]   == 4'd0);

    // A digit is a leading zero only if it and every more-significant digit
    // are zero; digit 0 always shows so "0" is still visible.
    always_comb begin
        blank_digit = 1'b0;
        if (eff_blz) begin
            case (index)
                2'd3:    blank_digit = z3;
                2'd2:    blank_digit = z3 && z2;
                2'd1:    blank_digit = z3 && z2 && z1;
                default: blank_digit = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prescaler <= '0;
            index     <= 2'd0;
        end else if (enable) begin
            prescaler <= tick ? '0 : prescaler + PW'(1);
            if (tick) begin
                index <= index + 2'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shadow_bcd <= '0;
            shadow_dp  <= '0;
            shadow_blz <= 1'b0;
        end else if (load) begin
            shadow_bcd <= bcd_in;
            shadow_dp  <= dp_in;
            shadow_blz <= blank_lz;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            an  <= 4'b1111;
            seg <= SEG_OFF;
            dp  <= 1'b1;
        end else if (!enable) begin
            an  <= 4'b1111;
            seg <= SEG_OFF;
            dp  <= 1'b1;
        end else begin
            an  <= ~(4'b0001 << index);
            seg <= blank_digit ? SEG_OFF : pattern;
            dp  <= blank_digit ? 1'b1 : ~eff_dp[index];
        end
    end

endmodule

// File: tb/tb_bcd_scan_display.sv
// Purpose: self-checking bench for bcd_scan_display with REFRESH_DIV = 4.
// Latency: expectations are queued before each clock edge and checked 1 ns after it.
// Backpressure: n/a.
module tb_bcd_scan_display;

    localparam logic [6:0] S0  = 7'b1000000;
    localparam logic [6:0] S1  = 7'b1111001;
    localparam logic [6:0] S2  = 7'b0100100;
    localparam logic [6:0] S3  = 7'b0110000;
    localparam logic [6:0] S4  = 7'b0011001;
    localparam logic [6:0] S5  = 7'b0010010;
    localparam logic [6:0] S6  = 7'b0000010;
    localparam logic [6:0] S7  = 7'b1111000;
    localparam logic [6:0] S8  = 7'b0000000;
    localparam logic [6:0] S9  = 7'b0010000;
    localparam logic [6:0] SD  = 7'b0111111;
    localparam logic [6:0] OFF = 7'b1111111;
    localparam int NV = 9;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        enable = 1'b0;
    logic [15:0] bcd_in = '0;
    logic [3:0]  dp_in = '0;
    logic        blank_lz = 1'b0;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;

    bcd_scan_display #(.REFRESH_DIV(4)) dut (
        .clk      (clk),
        .reset    (reset),
        .enable   (enable),
        .bcd_in   (bcd_in),
        .dp_in    (dp_in),
        .blank_lz (blank_lz),
        .an       (an),
        .seg      (seg),
        .dp       (dp)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
        int         tag;
    } exp_t;

    typedef struct packed {
        logic [15:0]     bcd;
        logic [3:0]      dpi;
        logic            blz;
        logic [3:0][6:0] eseg;   // expected pattern per digit, [3] = digit 3
        logic [3:0]      edp;    // expected dp per digit
    } vec_t;

    exp_t       sb[$];
    exp_t       mon_e;
    vec_t       tv [NV];
    logic [3:0] an_exp [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    int         vectors = 0;
    int         miscompares = 0;

    task automatic check(string name, logic [3:0] a, logic [6:0] s, logic d,
                         logic [3:0] ea, logic [6:0] es, logic ed);
        vectors++;
        if (a !== ea || s !== es || d !== ed) begin
            miscompares++;
            $display("FAIL %s: got an=%b seg=%b dp=%b, want an=%b seg=%b dp=%b",
                     name, a, s, d, ea, es, ed);
        end
    endtask

    task automatic push(int tag, logic [3:0] a, logic [6:0] s, logic d);
        exp_t e;
        e.an  = a;
        e.seg = s;
        e.dp  = d;
        e.tag = tag;
        sb.push_back(e);
    endtask

    // Scoreboard consumer: one queued expectation per clock edge.
    always @(posedge clk) begin
        #1;
        if (sb.size() > 0) begin
            mon_e = sb.pop_front();
            check($sformatf("scan_%0d", mon_e.tag), an, seg, dp, mon_e.an, mon_e.seg, mon_e.dp);
        end
    end

    task automatic do_reset();
        @(negedge clk);
        enable = 1'b0;
        reset  = 1'b1;
        #1;
        check("reset_async", an, seg, dp, 4'b1111, OFF, 1'b1);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running, want finished");
        $fatal(1);
    end

    initial begin
        tv[0] = '{16'h1234, 4'b0000, 1'b0, {S1, S2, S3, S4},    4'b1111};
        tv[1] = '{16'h0050, 4'b0000, 1'b1, {OFF, OFF, S5, S0},  4'b1111};
        tv[2] = '{16'h00A0, 4'b0010, 1'b0, {S0, S0, SD, S0},    4'b1101};
        tv[3] = '{16'h0000, 4'b1111, 1'b1, {OFF, OFF, OFF, S0}, 4'b1110};
        tv[4] = '{16'h9876, 4'b1001, 1'b1, {S9, S8, S7, S6},    4'b0110};
        tv[5] = '{16'h0F05, 4'b0000, 1'b1, {OFF, SD, S0, S5},   4'b1111};
        tv[6] = '{16'h0100, 4'b0100, 1'b1, {OFF, S1, S0, S0},   4'b1011};
        tv[7] = '{16'h0000, 4'b0000, 1'b0, {S0, S0, S0, S0},    4'b1111};
        tv[8] = '{16'hFEBC, 4'b0000, 1'b0, {SD, SD, SD, SD},    4'b1111};

        // Power-on reset with no clock edge yet.
        #1 reset = 1'b1;
        #1 check("reset_no_edge", an, seg, dp, 4'b1111, OFF, 1'b1);
        @(negedge clk);
        reset = 1'b0;

        // Table: two full frames per vector, each digit held 4 cycles.
        for (int v = 0; v < NV; v++) begin
            do_reset();
            @(negedge clk);
            bcd_in   = tv[v].bcd;
            dp_in    = tv[v].dpi;
            blank_lz = tv[v].blz;
            enable   = 1'b1;
            for (int c = 0; c < 32; c++) begin
                if (c > 0) @(negedge clk);
                push(v * 100 + c, an_exp[(c / 4) % 4], tv[v].eseg[(c / 4) % 4],
                     tv[v].edp[(c / 4) % 4]);
            end
            @(negedge clk);
            enable = 1'b0;
            push(v * 100 + 99, 4'b1111, OFF, 1'b1);
        end

        // Mid-frame input change is deferred to the next frame.
        do_reset();
        @(negedge clk);
        bcd_in = 16'h1111; dp_in = 4'b0000; blank_lz = 1'b0; enable = 1'b1;
        for (int c = 0; c < 32; c++) begin
            if (c > 0) @(negedge clk);
            if (c == 4) bcd_in = 16'h2222;
            push(1000 + c, an_exp[(c / 4) % 4], (c < 16) ? S1 : S2, 1'b1);
        end

        // Enable dropped for 10 cycles while digit 2 is two cycles in.
        do_reset();
        @(negedge clk);
        bcd_in = 16'h1234; enable = 1'b1;
        for (int c = 0; c < 10; c++) begin
            if (c > 0) @(negedge clk);
            push(2000 + c, an_exp[c / 4], tv[0].eseg[c / 4], 1'b1);
        end
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            enable = 1'b0;
            push(2100 + k, 4'b1111, OFF, 1'b1);
        end
        @(negedge clk);
        enable = 1'b1;
        for (int c = 0; c < 10; c++) begin
            if (c > 0) @(negedge clk);
            if (c < 2)      push(2200 + c, an_exp[2], S2, 1'b1);
            else if (c < 6) push(2200 + c, an_exp[3], S1, 1'b1);
            else            push(2200 + c, an_exp[0], S4, 1'b1);
        end

        // Asynchronous reset pulsed between edges in the middle of digit 1.
        do_reset();
        @(negedge clk);
        bcd_in = 16'h1234; enable = 1'b1;
        for (int c = 0; c < 6; c++) begin
            if (c > 0) @(negedge clk);
            push(3000 + c, an_exp[c / 4], tv[0].eseg[c / 4], 1'b1);
        end
        @(negedge clk);
        #2 reset = 1'b1;
        #1 check("reset_mid_scan", an, seg, dp, 4'b1111, OFF, 1'b1);
        @(negedge clk);
        check("reset_held", an, seg, dp, 4'b1111, OFF, 1'b1);
        reset = 1'b0;
        for (int c = 0; c < 8; c++) begin
            if (c > 0) @(negedge clk);
            push(3100 + c, an_exp[c / 4], tv[0].eseg[c / 4], 1'b1);
        end

        repeat (3) @(posedge clk);
        #2;
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL drain: got %0d pending expectations, want 0", sb.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/bcd_scan_display.md
BCD_SCAN_DISPLAY -- requirements
Module: bcd_scan_display

Interface
REQ-001 Parameter REFRESH_DIV, default 50000, clock cycles each digit stays lit; legal range >= 2.
REQ-002 clk  input  1  rising-edge system clock; the only clock.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 enable  input  1  high = scan runs; low = display blanked, scan frozen.
REQ-005 bcd_in  input  16  four BCD digits; [15:12] is the most-significant digit (digit 3), [3:0] is digit 0.
REQ-006 dp_in  input  4  decimal point request per digit, bit n = digit n, active-high.
REQ-007 blank_lz  input  1  high = suppress leading zeros.
REQ-008 an  output  4  digit anode select, active-low, one-hot-low while scanning.
REQ-009 seg  output  7  segments {g,f,e,d,c,b,a}, seg[0]=a, active-low.
REQ-010 dp  output  1  decimal point segment, active-low.

Function
REQ-011 Prescaler counts 0..REFRESH_DIV-1 and wraps to 0; width is clog2(REFRESH_DIV).
REQ-012 Scan tick = enable high and prescaler at REFRESH_DIV-1.
REQ-013 On each scan tick, digit index (2 bits) increments: 0->1->2->3->0.
REQ-014 Shadow registers capture bcd_in, dp_in and blank_lz in every cycle with enable high, index 0 and prescaler 0.
REQ-015 The shadow load of REQ-014 includes the first enabled cycle after reset.
REQ-016 Mid-frame input changes do not affect the displayed frame.
REQ-017 an, seg and dp are registered outputs, computed from the index and shadow values of the previous cycle (1-cycle latency).
REQ-018 Digit n active: an bit n = 0, all other an bits = 1.
REQ-019 Decode codes 0-9 to standard seven-segment patterns; example values: 0 = 1000000, 4 = 0011001, 5 = 0010010, 8 = 0000000.
REQ-020 Invalid codes 10-15 display a dash, seg = 0111111.
REQ-021 Leading-zero blanking, with shadow blank_lz high, applies to digits 3, 2, 1 only.
REQ-022 With blank_lz high, digit k (k = 3, 2 or 1) is blanked when it and all higher digits are 0; digit 0 is never blanked.
REQ-023 A blanked digit drives an for that digit as normal, with seg = 1111111 and dp = 1.
REQ-024 dp = ~shadow_dp[index]; dp is forced to 1 when the digit is blanked.
REQ-025 enable low: prescaler, index and shadow registers hold.
REQ-026 enable low: next cycle an = 1111, seg = 1111111, dp = 1.
REQ-027 enable re-asserted: scanning resumes from the held index and prescaler.

Reset
REQ-028 While reset is asserted, with no clock edge required: prescaler = 0, index = 0, shadow = 0, an = 1111, seg = 1111111, dp = 1.
REQ-029 Reset asserted mid-scan overrides all other activity immediately.
REQ-030 After reset deassertion, the first enabled cycle loads the shadow registers (REQ-014).

Structure
REQ-031 A shared package holds: the segment pattern constants for 0-9, the dash pattern, the all-off pattern, and the DIGIT_COUNT = 4 constant.
REQ-032 One combinational sub-module, bcd_to_7seg (4-bit code in, 7-bit active-low pattern out), is instantiated once.
REQ-033 Prescaler, index, shadow, blanking logic and output registers reside in bcd_scan_display.

Verification
REQ-034 All scenarios run with REFRESH_DIV = 4.
REQ-035 Reset, then enable = 1, bcd_in = 16'h1234, blank_lz = 0, dp_in = 0 -> an/seg sequence 1110/0011001 (4), 1101/0110000 (3), 1011/0100100 (2), 0111/1111001 (1); each digit held 4 cycles; sequence repeats.
REQ-036 bcd_in = 16'h0050, blank_lz = 1 -> digits 3 and 2 give an = 0111 and 1011 with seg = 1111111; digit 1 gives seg = 0010010; digit 0 gives seg = 1000000.
REQ-037 bcd_in = 16'h00A0, dp_in = 4'b0010 -> digit 1 shows seg = 0111111 with dp = 0; other digits show dp = 1.
REQ-038 bcd_in changed from 16'h1111 to 16'h2222 while index = 1 -> digits 1-3 still show 1 for that frame; 2 appears from the next index-0 frame.
REQ-039 enable dropped for 10 cycles at index 2 -> an = 1111 from the next cycle; on re-enable, digit 2 resumes with its remaining prescaler count.
REQ-040 Async reset pulsed between clock edges -> an = 1111, seg = 1111111 and dp = 1 immediately; scan restarts at digit 0.
